// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with a word-by-word refill FSM.
// Optional hit/miss statistics counters are enabled with INST_CACHE_STAT_EN.
//
// state | meaning
// IDLE  | lookups served combinationally; a miss starts a refill
// FILL  | fetching the latched line one word per mem_ack; core stalled
module inst_cache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
`ifdef INST_CACHE_STAT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - 2 - OW - IW;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q;
  logic [TW-1:0]     tag_q  [LINES];
  logic [31:0]       data_q [LINES][WORDS];
  logic [TW-1:0]     fill_tag_q;
  logic [IW-1:0]     idx_q;
  logic [OW-1:0]     cnt_q;
  logic              kill_q;
  logic              mem_req_q;
  logic [31:0]       mem_addr_q;

  logic [OW-1:0]     offset;
  logic [IW-1:0]     index;
  logic [TW-1:0]     tag;
  logic              hit, start, ack, last;
  logic              unused_byte_bits;

  assign offset = inst_addr[2 +: OW];
  assign index  = inst_addr[2+OW +: IW];
  assign tag    = inst_addr[31 -: TW];
  assign unused_byte_bits = ^inst_addr[1:0];

  assign hit   = inst_ren & valid_q[index] & (tag_q[index] == tag) & (state_q == IDLE);
  assign start = (state_q == IDLE) & inst_ren & ~hit;
  assign ack   = (state_q == FILL) & mem_req_q & mem_ack;
  assign last  = ack & (cnt_q == OW'(WORDS-1));

  assign inst_data  = hit ? data_q[index][offset] : '0;
  assign inst_stall = (inst_ren & ~hit) | (state_q == FILL);
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      fill_tag_q <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      kill_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      if (start) begin
        fill_tag_q <= tag;
        idx_q      <= index;
        cnt_q      <= '0;
        kill_q     <= 1'b0;
        mem_req_q  <= 1'b1;
        mem_addr_q <= {inst_addr[31:2+OW], {(2+OW){1'b0}}};
      end
      if (ack) begin
        cnt_q <= cnt_q + 1'b1;
        if (last) begin
          mem_req_q      <= 1'b0;
          valid_q[idx_q] <= ~kill_q;
        end else begin
          mem_addr_q <= mem_addr_q + 32'd4;
        end
      end
      // Placed last so a flush on the final-ack edge still leaves the line invalid.
      if (flush) begin
        valid_q <= '0;
        if (state_q == FILL) kill_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ack)  data_q[idx_q][cnt_q] <= mem_data;
    if (last) tag_q[idx_q]         <= fill_tag_q;
  end

`ifdef INST_CACHE_STAT_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit)   hit_count_q  <= hit_count_q + 32'd1;
      if (start) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: fills, hits, conflicts, wait states, flush and reset.
// A small memory responder acks requests every `period` cycles.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
`ifdef INST_CACHE_STAT_EN
  logic [31:0] hit_count, miss_count;
`endif

  inst_cache #(.LINES(16), .WORDS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_ren   (inst_ren),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .inst_stall (inst_stall),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data)
`ifdef INST_CACHE_STAT_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          period = 1;
  int          wcnt = 0;
  logic        stray = 1'b0;
  logic [31:0] req_log [64];
  int          nreq;
  int          stalls;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], 16'hC0DE} ^ 32'h1234_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        wcnt     = 0;
        mem_ack  = stray;
        mem_data = 32'hBAD0_BAD0;
      end else if (wcnt == period - 1) begin
        wcnt     = 0;
        mem_ack  = 1'b1;
        mem_data = word_at(mem_addr);
      end else begin
        wcnt++;
        mem_ack  = 1'b0;
        mem_data = 32'hBAD0_BAD0;
      end
    end
  end

  // Holds inst_addr until the stall clears; flush pulses in cycle flush_at (cycle 0 = request).
  task automatic fetch(input logic [31:0] a, input int flush_at, output int st);
    int cyc;
    @(negedge clk);
    inst_ren  = 1'b1;
    inst_addr = a;
    cyc       = 0;
    flush     = (flush_at == 0);
    nreq      = 0;
    st        = 0;
    #1;
    while (inst_stall && st < 200) begin
      st++;
      @(negedge clk);
      cyc++;
      flush = (cyc == flush_at);
      #1;
      if (mem_req && nreq < 64) begin
        req_log[nreq] = mem_addr;
        nreq++;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    inst_ren  = 1'b0;
    inst_addr = '0;
    flush     = 1'b0;
    #1;
    check("rst_stall", {31'd0, inst_stall}, 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Cold miss
    fetch(32'h40, -1, stalls);
    check("cold_stalls", stalls, 32'd5);
    check("cold_nreq", nreq, 32'd4);
    check("cold_addr0", req_log[0], 32'h40);
    check("cold_addr1", req_log[1], 32'h44);
    check("cold_addr2", req_log[2], 32'h48);
    check("cold_addr3", req_log[3], 32'h4C);
    check("cold_data", inst_data, word_at(32'h40));

    // Same-line hits
    fetch(32'h44, -1, stalls);
    check("hit44_stalls", stalls, 32'd0);
    check("hit44_data", inst_data, word_at(32'h44));
    fetch(32'h48, -1, stalls);
    check("hit48_stalls", stalls, 32'd0);
    check("hit48_data", inst_data, word_at(32'h48));
    fetch(32'h4C, -1, stalls);
    check("hit4C_stalls", stalls, 32'd0);
    check("hit4C_data", inst_data, word_at(32'h4C));
    @(negedge clk);
    inst_ren = 1'b0;
    #1;
    check("idle_stall", {31'd0, inst_stall}, 32'd0);
    check("idle_data", inst_data, 32'd0);
`ifdef INST_CACHE_STAT_EN
    check("hit_count", hit_count, 32'd4);
    check("miss_count", miss_count, 32'd1);
`endif

    // Stray acks while idle must be ignored
    stray = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("stray_req", {31'd0, mem_req}, 32'd0);
    fetch(32'h40, -1, stalls);
    check("stray_hit", stalls, 32'd0);
    check("stray_data", inst_data, word_at(32'h40));
    stray = 1'b0;

    // Conflict eviction
    fetch(32'h440, -1, stalls);
    check("conf_stalls", stalls, 32'd5);
    check("conf_addr0", req_log[0], 32'h440);
    check("conf_addr3", req_log[3], 32'h44C);
    check("conf_data", inst_data, word_at(32'h440));
    fetch(32'h40, -1, stalls);
    check("evict_stalls", stalls, 32'd5);
    check("evict_data", inst_data, word_at(32'h40));

    // Memory wait states
    period = 3;
    fetch(32'h100, -1, stalls);
    check("wait_stalls", stalls, 32'd13);
    check("wait_nreq", nreq, 32'd12);
    for (int i = 0; i < 12; i++)
      check("wait_addr_hold", req_log[i], 32'h100 + 32'(4 * (i / 3)));
    check("wait_data", inst_data, word_at(32'h100));
    period = 1;
    fetch(32'h10C, -1, stalls);
    check("wait_hit_stalls", stalls, 32'd0);
    check("wait_hit_data", inst_data, word_at(32'h10C));

    // Flush during fill: line left invalid and refilled
    fetch(32'h80, 2, stalls);
    check("fflush_stalls", stalls, 32'd10);
    check("fflush_nreq", nreq, 32'd8);
    check("fflush_data", inst_data, word_at(32'h80));
    fetch(32'h80, -1, stalls);
    check("refill_hit", stalls, 32'd0);
    // Flush coinciding with a hit still hits, then the line misses
    fetch(32'h84, 0, stalls);
    check("iflush_hit", stalls, 32'd0);
    check("iflush_data", inst_data, word_at(32'h84));
    fetch(32'h88, -1, stalls);
    check("iflush_miss", stalls, 32'd5);
    check("iflush_refill", inst_data, word_at(32'h88));
    // Flush on the final-ack edge
    fetch(32'hC0, 4, stalls);
    check("lastack_flush", stalls, 32'd10);
    check("lastack_data", inst_data, word_at(32'hC0));

    // Async reset mid-fill
    @(negedge clk);
    inst_ren  = 1'b1;
    inst_addr = 32'h200;
    flush     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("midfill_req", {31'd0, mem_req}, 32'd1);
    check("midfill_addr", mem_addr, 32'h204);
    #1 rst = 1'b1;
    #1;
    check("arst_req", {31'd0, mem_req}, 32'd0);
    inst_ren = 1'b0;
    #1;
    check("arst_idle", {31'd0, inst_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fetch(32'h200, -1, stalls);
    check("arst_refetch", stalls, 32'd5);
    check("arst_data", inst_data, word_at(32'h200));
    fetch(32'h204, -1, stalls);
    check("arst_hit", stalls, 32'd0);
    check("arst_hit_data", inst_data, word_at(32'h204));

    @(negedge clk);
    inst_ren = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
